axis_pkt_gen: RTL and testbench
===============================

AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 Parameter MTU_BYTES, default 1500: largest packet byte length emitted.
REQ-002 Parameter MAX_PKTS, default 256: largest packet count per run.
REQ-003 Parameter CNT_W, default $clog2(MAX_PKTS)+1: width of the packet-count fields.
REQ-004 Port clk, input, 1: sole clock.
REQ-005 Port aresetn, input, 1: reset, asynchronous and active-low.
REQ-006 Port axis_out, AXIS_int.Master, interface: packet stream; DATA_BYTES and DEST_WIDTH are taken from the interface.
REQ-007 Port start, input, 1: single-cycle request to begin a run.
REQ-008 Port num_pkts, input, CNT_W: number of packets in the run.
REQ-009 Port pkt_blen, input, $clog2(MTU_BYTES)+1: byte length of every packet.
REQ-010 Port dest_base, input, DEST_WIDTH: tdest of packet 0.
REQ-011 Port num_dests, input, DEST_WIDTH: number of distinct tdest values rotated through.
REQ-012 Port seed, input, 8: payload seed.
REQ-013 Port err_pkt_idx, input, CNT_W: index of the packet to corrupt (see Configuration).
REQ-014 Port busy, output, 1: high while a run is in progress.
REQ-015 Port done, output, 1: one-cycle pulse when a run completes.
REQ-016 Port pkts_sent, output, CNT_W: number of packets fully accepted in the current or last run.

Function
REQ-017 The FSM SHALL have three states, IDLE, SEND and DONE: IDLE->SEND on start; SEND->DONE when the tlast beat of packet num_pkts-1 is accepted; DONE->IDLE after one cycle.
REQ-018 The block SHALL latch all configuration inputs on the start cycle; later changes SHALL have no effect on the current run.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 start with num_pkts=0 SHALL go IDLE->DONE directly, with no beats and a done pulse.
REQ-021 The first tvalid SHALL assert on the cycle after start is accepted.
REQ-022 Back-to-back packets SHALL have no idle cycle between them while tready=1.
REQ-023 Byte k of packet p SHALL be (seed+p+k) mod 256, with byte 0 in tdata[7:0].
REQ-024 tdest of packet p SHALL be dest_base+(p mod num_dests), truncated to DEST_WIDTH; num_dests=0 SHALL be treated as 1.
REQ-025 Effective length SHALL be pkt_blen clamped to the range [1, MTU_BYTES].
REQ-026 Each packet SHALL occupy ceil(len/DATA_BYTES) beats; tlast SHALL be set on the final beat only.
REQ-027 tkeep and tstrb SHALL be all-ones except on the final beat, where the low (len mod DATA_BYTES) bits are set, or all bits when the remainder is 0.
REQ-028 tid and tuser SHALL be 0.
REQ-029 Unused final-beat bytes SHALL be 0.
REQ-030 Once tvalid is high, tvalid, tdata, tkeep, tlast and tdest SHALL hold stable until tready; tvalid SHALL never deassert without a handshake.
REQ-031 pkts_sent SHALL clear on start and increment on each accepted tlast beat.
REQ-032 pkts_sent SHALL hold its value in IDLE.
REQ-033 busy SHALL be high in SEND and DONE.

Reset
REQ-034 On aresetn low, all outputs SHALL clear asynchronously: tvalid=0, tlast=0, busy=0, done=0, pkts_sent=0; the FSM SHALL return to IDLE.
REQ-035 Reset mid-packet SHALL abandon the packet with no tlast emitted.
REQ-036 After reset deassertion the first start SHALL begin from packet 0.

Configuration
REQ-037 With AXIS_PKT_GEN_ERR_INJECT_EN defined, byte 0 of packet err_pkt_idx SHALL be XORed with 8'hFF; an err_pkt_idx at or above num_pkts SHALL corrupt nothing.
REQ-038 Without AXIS_PKT_GEN_ERR_INJECT_EN, err_pkt_idx SHALL remain a port, be ignored, and the block SHALL add no logic for it.

Verification
REQ-039 DATA_BYTES=8, num_pkts=3, pkt_blen=20, seed=8'h10, tready=1 -> 9 beats; packet 0 beats 0-1 hold bytes 10..1F, beat 2 has tkeep=8'h0F and tlast=1; done pulses; pkts_sent=3.
REQ-040 dest_base=2, num_dests=3, num_pkts=5 -> tdest sequence is 2,3,4,2,3.
REQ-041 Random tready at 30% duty -> no payload change and no tvalid drop while stalled; output matches axis_packet_checker expectations with zero errors.
REQ-042 pkt_blen=0, then pkt_blen=MTU_BYTES+7 -> 1-byte packets with tkeep=8'h01, then MTU_BYTES-byte packets.
REQ-043 aresetn asserted on beat 2 of packet 1 -> tvalid=0 immediately; a new start with num_pkts=1 emits a clean packet 0.
REQ-044 With AXIS_PKT_GEN_ERR_INJECT_EN, err_pkt_idx=1, seed=0 -> byte 0 of packet 1 is 8'hFE and the checker flags exactly one packet; without the macro, zero errors.

Source files
------------

// File: rtl/axis_pkt_gen_if.sv
// AXI4-Stream bundle shared by the packet generator and whatever consumes it.
// DATA_BYTES / DEST_WIDTH here must match the generator's parameters of the same name.
interface AXIS_int #(
    parameter int DATA_BYTES = 8,
    parameter int DEST_WIDTH = 4,
    parameter int ID_WIDTH   = 1,
    parameter int USER_WIDTH = 1
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_BYTES*8-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic [DATA_BYTES-1:0]   tstrb;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;

    modport Master (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, input tready);
    modport Slave  (input tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: num_pkts packets of pkt_blen bytes, payload (seed+p+k), rotating tdest.
// Define AXIS_PKT_GEN_ERR_INJECT_EN to flip byte 0 of packet err_pkt_idx.
module axis_pkt_gen #(
    parameter int MTU_BYTES  = 1500,
    parameter int MAX_PKTS   = 256,
    parameter int CNT_W      = $clog2(MAX_PKTS) + 1,
    parameter int DATA_BYTES = 8,
    parameter int DEST_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        aresetn,
    AXIS_int.Master                     axis_out,
    input  logic                        start,
    input  logic [CNT_W-1:0]            num_pkts,
    input  logic [$clog2(MTU_BYTES):0]  pkt_blen,
    input  logic [DEST_WIDTH-1:0]       dest_base,
    input  logic [DEST_WIDTH-1:0]       num_dests,
    input  logic [7:0]                  seed,
    input  logic [CNT_W-1:0]            err_pkt_idx,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_W-1:0]            pkts_sent
);
    localparam int DB    = DATA_BYTES;
    localparam int LEN_W = $clog2(MTU_BYTES) + 1;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      num_q, pkt_q, sent_q;
    logic [LEN_W-1:0]      len_q, k_q;
    logic [DEST_WIDTH-1:0] dbase_q, ndest_q, doff_q;
    logic [7:0]            seed_q;
    logic                  tvalid_q, tlast_q, busy_q, done_q;
    logic [DB*8-1:0]       tdata_q;
    logic [DB-1:0]         tkeep_q;
    logic [DEST_WIDTH-1:0] tdest_q;

    logic [LEN_W-1:0]      len_in, b_len, b_k;
    logic [DEST_WIDTH-1:0] ndest_in, b_doff, b_dest;
    logic [CNT_W-1:0]      b_p;
    logic [7:0]            b_seed;
    logic [DB*8-1:0]       b_data;
    logic [DB-1:0]         b_keep;
    logic                  b_last;

`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
    logic [CNT_W-1:0]      err_q, b_err;
`else
    logic                  unused_err;
    assign unused_err = ^err_pkt_idx;
`endif

    // Next beat to present: first beat of the run (from live inputs in IDLE),
    // next beat of the current packet, or first beat of the following packet.
    always_comb begin
        len_in = pkt_blen;
        if (pkt_blen == '0)                   len_in = LEN_W'(1);
        else if (int'(pkt_blen) > MTU_BYTES)  len_in = LEN_W'(MTU_BYTES);
        ndest_in = (num_dests == '0) ? DEST_WIDTH'(1) : num_dests;

        b_seed = seed_q;
        b_len  = len_q;
        b_p    = pkt_q;
        b_k    = k_q + LEN_W'(DB);
        b_doff = doff_q;
        b_dest = dbase_q;
`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
        b_err  = err_q;
`endif
        if (state_q == IDLE) begin
            b_seed = seed;
            b_len  = len_in;
            b_p    = '0;
            b_k    = '0;
            b_doff = '0;
            b_dest = dest_base;
`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
            b_err  = err_pkt_idx;
`endif
        end else if (tlast_q) begin
            b_p    = pkt_q + CNT_W'(1);
            b_k    = '0;
            b_doff = (doff_q + DEST_WIDTH'(1) == ndest_q) ? '0 : doff_q + DEST_WIDTH'(1);
        end

        b_data = '0;
        b_keep = '0;
        for (int i = 0; i < DB; i++) begin
            if (int'(b_k) + i < int'(b_len)) begin
                b_keep[i]      = 1'b1;
                b_data[i*8 +: 8] = b_seed + 8'(b_p) + 8'(b_k) + 8'(i);
            end
        end
`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
        if (b_p == b_err && b_k == '0) b_data[7:0] = b_data[7:0] ^ 8'hFF;
`endif
        b_last = int'(b_k) + DB >= int'(b_len);
        b_dest = b_dest + b_doff;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            num_q    <= '0;
            pkt_q    <= '0;
            sent_q   <= '0;
            len_q    <= '0;
            k_q      <= '0;
            dbase_q  <= '0;
            ndest_q  <= '0;
            doff_q   <= '0;
            seed_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tdest_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
            err_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    num_q   <= num_pkts;
                    len_q   <= len_in;
                    dbase_q <= dest_base;
                    ndest_q <= ndest_in;
                    seed_q  <= seed;
`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
                    err_q   <= err_pkt_idx;
`endif
                    sent_q  <= '0;
                    busy_q  <= 1'b1;
                    if (num_pkts == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= SEND;
                        tvalid_q <= 1'b1;
                        tdata_q  <= b_data;
                        tkeep_q  <= b_keep;
                        tlast_q  <= b_last;
                        tdest_q  <= b_dest;
                        pkt_q    <= b_p;
                        k_q      <= b_k;
                        doff_q   <= b_doff;
                    end
                end
                SEND: if (tvalid_q && axis_out.tready) begin
                    if (tlast_q) sent_q <= sent_q + CNT_W'(1);
                    if (tlast_q && pkt_q == num_q - CNT_W'(1)) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                    end else begin
                        tdata_q <= b_data;
                        tkeep_q <= b_keep;
                        tlast_q <= b_last;
                        tdest_q <= b_dest;
                        pkt_q   <= b_p;
                        k_q     <= b_k;
                        doff_q  <= b_doff;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign axis_out.tvalid = tvalid_q;
    assign axis_out.tdata  = tdata_q;
    assign axis_out.tkeep  = tkeep_q;
    assign axis_out.tstrb  = tkeep_q;
    assign axis_out.tlast  = tlast_q;
    assign axis_out.tdest  = tdest_q;
    assign axis_out.tid    = '0;
    assign axis_out.tuser  = '0;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pkts_sent       = sent_q;
endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: randomized runs scored against a byte-level packet model.
module tb_axis_pkt_gen;
    localparam int DB   = 8;
    localparam int DW   = 4;
    localparam int MTU  = 64;
    localparam int MAXP = 16;
    localparam int CW   = $clog2(MAXP) + 1;
    localparam int LW   = $clog2(MTU) + 1;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_pkts = '0;
    logic [CW-1:0] err_pkt_idx = '0;
    logic [LW-1:0] pkt_blen = '0;
    logic [DW-1:0] dest_base = '0;
    logic [DW-1:0] num_dests = '0;
    logic [7:0]    seed = '0;
    logic          busy, done;
    logic [CW-1:0] pkts_sent;

    AXIS_int #(.DATA_BYTES(DB), .DEST_WIDTH(DW)) axo ();

    axis_pkt_gen #(.MTU_BYTES(MTU), .MAX_PKTS(MAXP), .DATA_BYTES(DB), .DEST_WIDTH(DW)) dut (
        .clk(clk), .aresetn(aresetn), .axis_out(axo), .start(start),
        .num_pkts(num_pkts), .pkt_blen(pkt_blen), .dest_base(dest_base),
        .num_dests(num_dests), .seed(seed), .err_pkt_idx(err_pkt_idx),
        .busy(busy), .done(done), .pkts_sent(pkts_sent)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0]   d;
        logic [7:0]    k;
        logic          l;
        logic [DW-1:0] t;
    } beat_t;

    beat_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic scramble_cfg();
        num_pkts    = CW'($urandom_range(0, MAXP));
        pkt_blen    = LW'($urandom_range(0, 127));
        dest_base   = DW'($urandom);
        num_dests   = DW'($urandom);
        seed        = 8'($urandom);
        err_pkt_idx = CW'($urandom);
    endtask

    // One run: build the expected beat list from the packet rules, then drive and score.
    task automatic run(input int n, input int len, input int db, input int nd, input int sd,
                       input int err, input int rdy_pct, input string tag);
        int    eff, ndd, nb, lasts, cyc;
        bit    prev_stall, full;
        beat_t bt, prev, cur, e;

        exp_q.delete();
        eff = (len == 0) ? 1 : ((len > MTU) ? MTU : len);
        ndd = (nd == 0) ? 1 : nd;
        nb  = (eff + DB - 1) / DB;
        for (int p = 0; p < n; p++) begin
            for (int b = 0; b < nb; b++) begin
                bt.d = '0;
                bt.k = '0;
                for (int i = 0; i < DB; i++) begin
                    if (b * DB + i < eff) begin
                        bt.d[i*8 +: 8] = 8'((sd + p + b * DB + i) % 256);
                        bt.k[i]        = 1'b1;
                    end
                end
`ifdef AXIS_PKT_GEN_ERR_INJECT_EN
                if (p == err && b == 0) bt.d[7:0] = bt.d[7:0] ^ 8'hFF;
`endif
                bt.l = (b == nb - 1);
                bt.t = DW'((db + p % ndd) % (1 << DW));
                exp_q.push_back(bt);
            end
        end

        @(negedge clk);
        num_pkts    = CW'(n);
        pkt_blen    = LW'(len);
        dest_base   = DW'(db);
        num_dests   = DW'(nd);
        seed        = 8'(sd);
        err_pkt_idx = CW'(err);
        axo.tready  = 1'b0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_cfg();
        if (n > 0) chk({tag, " first tvalid"}, 64'(axo.tvalid), 64'(1));

        full       = (rdy_pct >= 100);
        prev_stall = 1'b0;
        lasts      = 0;
        prev       = '{default: '0};
        for (cyc = 0; cyc < 3000; cyc++) begin
            cur.d = axo.tdata;
            cur.k = axo.tkeep;
            cur.l = axo.tlast;
            cur.t = axo.tdest;
            chk({tag, " pkts_sent"}, 64'(pkts_sent), 64'(lasts));
            if (prev_stall) begin
                chk({tag, " stall tvalid"}, 64'(axo.tvalid), 64'(1));
                chk({tag, " stall tdata"}, cur.d, prev.d);
                chk({tag, " stall tkeep"}, 64'(cur.k), 64'(prev.k));
                chk({tag, " stall tlast"}, 64'(cur.l), 64'(prev.l));
                chk({tag, " stall tdest"}, 64'(cur.t), 64'(prev.t));
            end
            if (full && exp_q.size() > 0) chk({tag, " no gap"}, 64'(axo.tvalid), 64'(1));
            if (done) begin
                chk({tag, " beats left at done"}, 64'(exp_q.size()), 64'(0));
                chk({tag, " busy at done"}, 64'(busy), 64'(1));
                break;
            end
            chk({tag, " busy"}, 64'(busy), 64'(1));
            if (cyc == 3 && exp_q.size() > 0) begin
                scramble_cfg();
                start = 1'b1;
            end
            axo.tready = ($urandom_range(0, 99) < rdy_pct);
            if (axo.tvalid && axo.tready) begin
                chk({tag, " beat expected"}, 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk({tag, " tdata"}, cur.d, e.d);
                    chk({tag, " tkeep"}, 64'(cur.k), 64'(e.k));
                    chk({tag, " tstrb"}, 64'(axo.tstrb), 64'(e.k));
                    chk({tag, " tlast"}, 64'(cur.l), 64'(e.l));
                    chk({tag, " tdest"}, 64'(cur.t), 64'(e.t));
                    chk({tag, " tid/tuser"}, 64'({axo.tid, axo.tuser}), 64'(0));
                    if (e.l) lasts++;
                end
            end
            prev_stall = axo.tvalid && !axo.tready;
            prev       = cur;
            @(negedge clk);
            start = 1'b0;
        end
        if (cyc >= 3000) chk({tag, " timeout waiting for done"}, 64'(cyc), 64'(0));
        @(negedge clk);
        chk({tag, " done one cycle"}, 64'(done), 64'(0));
        chk({tag, " busy after"}, 64'(busy), 64'(0));
        chk({tag, " final pkts_sent"}, 64'(pkts_sent), 64'(n));
        repeat (2) @(negedge clk);
        chk({tag, " pkts_sent held"}, 64'(pkts_sent), 64'(n));
        chk({tag, " idle tvalid"}, 64'(axo.tvalid), 64'(0));
    endtask

    initial begin
        axo.tready = 1'b0;
        #12;
        chk("reset tvalid", 64'(axo.tvalid), 64'(0));
        chk("reset tlast", 64'(axo.tlast), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset pkts_sent", 64'(pkts_sent), 64'(0));
        @(negedge clk);
        aresetn = 1'b1;

        run(3, 20, 0, 1, 8'h10, 20, 100, "basic");
        run(5, 16, 2, 3, $urandom_range(0, 255), 31, 100, "dest");
        for (int r = 0; r < 6; r++)
            run($urandom_range(1, 6), $urandom_range(0, MTU + 10), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 7), 30, "rand");
        run(2, 0, 1, 0, $urandom_range(0, 255), 9, 100, "len0");
        run(2, MTU + 7, 5, 2, $urandom_range(0, 255), 9, 60, "lenmax");
        run(0, 20, 0, 1, 0, 0, 100, "zero");
        run(3, 10, 0, 1, 0, 1, 100, "errinj");

        // Reset while packet 1 beat 2 is on the bus.
        @(negedge clk);
        num_pkts = CW'(3); pkt_blen = LW'(20); dest_base = '0; num_dests = DW'(1);
        seed = 8'($urandom); err_pkt_idx = CW'(15);
        axo.tready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst pre tvalid", 64'(axo.tvalid), 64'(1));
        aresetn = 1'b0;
        #1;
        chk("rst tvalid", 64'(axo.tvalid), 64'(0));
        chk("rst tlast", 64'(axo.tlast), 64'(0));
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst pkts_sent", 64'(pkts_sent), 64'(0));
        @(negedge clk);
        aresetn = 1'b1;
        run(1, 20, 3, 1, $urandom_range(0, 255), 0, 100, "post-rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
